// File: rtl/ex_mem_flag_stage_pkg.sv
// Shared constants for the EX/MEM flag stage: widths, flag bit positions
// inside the {V,Z,N} register and the conditional-branch codes.
package ex_mem_flag_stage_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;
    localparam int NFLAGS = 3;

    // Bit positions inside the {V,Z,N} flag vector
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [2:0] {
        BR_NE = 3'b000,
        BR_EQ = 3'b001,
        BR_GT = 3'b010,
        BR_LT = 3'b011,
        BR_GE = 3'b100,
        BR_LE = 3'b101,
        BR_OV = 3'b110,
        BR_UN = 3'b111
    } br_cond_e;

endpackage

// File: rtl/ex_mem_flag_stage_if.sv
// Bundle of the EX-side inputs and MEM/redirect-side outputs of the stage.
// master drives the EX side (ALU / decode / bench); slave is the stage itself.
interface ex_mem_flag_stage_if
    import ex_mem_flag_stage_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int RW = REG_W
);
    logic          stall;
    logic          flush;
    logic          ex_valid;
    logic [DW-1:0] alu_dst;
    logic          alu_v;
    logic          alu_z;
    logic          alu_n;
    logic [2:0]    flag_we;
    logic          ex_is_branch;
    logic [2:0]    ex_br_cond;
    logic [DW-1:0] ex_br_target;
    logic          ex_rf_we;
    logic [RW-1:0] ex_rf_waddr;
    logic          ex_mem_rd;
    logic          ex_mem_wr;
    logic [DW-1:0] ex_st_data;

    logic [2:0]    flags_q;
    logic          mem_valid;
    logic [DW-1:0] mem_result;
    logic [DW-1:0] mem_st_data;
    logic          mem_rf_we;
    logic          mem_mem_rd;
    logic          mem_mem_wr;
    logic [RW-1:0] mem_rf_waddr;
    logic          br_taken;
    logic [DW-1:0] br_target;

    modport master (
        output stall, flush, ex_valid, alu_dst, alu_v, alu_z, alu_n, flag_we,
               ex_is_branch, ex_br_cond, ex_br_target, ex_rf_we, ex_rf_waddr,
               ex_mem_rd, ex_mem_wr, ex_st_data,
        input  flags_q, mem_valid, mem_result, mem_st_data, mem_rf_we,
               mem_mem_rd, mem_mem_wr, mem_rf_waddr, br_taken, br_target
    );

    modport slave (
        input  stall, flush, ex_valid, alu_dst, alu_v, alu_z, alu_n, flag_we,
               ex_is_branch, ex_br_cond, ex_br_target, ex_rf_we, ex_rf_waddr,
               ex_mem_rd, ex_mem_wr, ex_st_data,
        output flags_q, mem_valid, mem_result, mem_st_data, mem_rf_we,
               mem_mem_rd, mem_mem_wr, mem_rf_waddr, br_taken, br_target
    );

endinterface

// File: rtl/ex_mem_flag_stage_branch_cond.sv
// Purely combinational branch-condition evaluator on a {V,Z,N} flag vector.
// Also used by the hazard unit's predictor checks, so it stays stateless.
module branch_cond
    import ex_mem_flag_stage_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [2:0] cond,
    output logic       taken
);

    logic v;
    logic z;
    logic n;

    assign v = flags[FLAG_V];
    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];

    // Decode the condition code into a taken decision
    always_comb begin
        taken = 1'b0;
        case (br_cond_e'(cond))
            BR_NE:   taken = ~z;
            BR_EQ:   taken = z;
            BR_GT:   taken = ~z & ~n;
            BR_LT:   taken = n;
            BR_GE:   taken = z | (~z & ~n);
            BR_LE:   taken = n | z;
            BR_OV:   taken = v;
            BR_UN:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with the architectural {V,Z,N} flag register and
// branch resolution. Branches resolve on the flags committed by older
// instructions; the redirect is registered (one cycle after EX).
module ex_mem_flag_stage
    import ex_mem_flag_stage_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int RW = REG_W
)(
    input  logic               clk,
    input  logic               rst_n,
    ex_mem_flag_stage_if.slave bus
);

    logic          live;
    logic          cond_true;
    logic          redirect;
    logic [2:0]    alu_flags;
    logic [2:0]    flags_reg;
    logic [2:0]    flags_next;

    logic          valid_reg;
    logic          rf_we_reg;
    logic          mem_rd_reg;
    logic          mem_wr_reg;
    logic          br_taken_reg;
    logic [DW-1:0] result_reg;
    logic [DW-1:0] st_data_reg;
    logic [RW-1:0] waddr_reg;
    logic [DW-1:0] br_target_reg;

    // flush and stall both suppress "live"; flush wins by bubbling below
    assign live = bus.ex_valid & ~bus.flush & ~bus.stall;

    assign alu_flags[FLAG_V] = bus.alu_v;
    assign alu_flags[FLAG_Z] = bus.alu_z;
    assign alu_flags[FLAG_N] = bus.alu_n;

    // Evaluated on the committed flags, so a branch that also writes flags
    // sees the pre-update values
    branch_cond u_branch_cond (
        .flags (flags_reg),
        .cond  (bus.ex_br_cond),
        .taken (cond_true)
    );

    assign redirect = live & bus.ex_is_branch & cond_true;

    generate
        for (genvar gi = 0; gi < NFLAGS; gi++) begin : g_flag
            assign flags_next[gi] = (live && bus.flag_we[gi]) ? alu_flags[gi] : flags_reg[gi];
        end
    endgenerate

    // Flag register: per-bit masked update, only from live instructions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg <= 3'b000;
        end else begin
            flags_reg <= flags_next;
        end
    end

    // Control bits: reload on flush or no-stall (flush forces live=0 => bubble)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg    <= 1'b0;
            rf_we_reg    <= 1'b0;
            mem_rd_reg   <= 1'b0;
            mem_wr_reg   <= 1'b0;
            br_taken_reg <= 1'b0;
        end else if (bus.flush || !bus.stall) begin
            valid_reg    <= live;
            rf_we_reg    <= live & bus.ex_rf_we;
            mem_rd_reg   <= live & bus.ex_mem_rd;
            mem_wr_reg   <= live & bus.ex_mem_wr;
            br_taken_reg <= redirect;
        end
    end

    // Data registers: only meaningful when valid, so they load on live only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg  <= '0;
            st_data_reg <= '0;
            waddr_reg   <= '0;
        end else if (live) begin
            result_reg  <= bus.alu_dst;
            st_data_reg <= bus.ex_st_data;
            waddr_reg   <= bus.ex_rf_waddr;
        end
    end

    // Redirect address is captured alongside a taken branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_target_reg <= '0;
        end else if (redirect) begin
            br_target_reg <= bus.ex_br_target;
        end
    end

    assign bus.flags_q      = flags_reg;
    assign bus.mem_valid    = valid_reg;
    assign bus.mem_result   = result_reg;
    assign bus.mem_st_data  = st_data_reg;
    assign bus.mem_rf_we    = rf_we_reg;
    assign bus.mem_mem_rd   = mem_rd_reg;
    assign bus.mem_mem_wr   = mem_wr_reg;
    assign bus.mem_rf_waddr = waddr_reg;
    assign bus.br_taken     = br_taken_reg;
    assign bus.br_target    = br_target_reg;

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Directed bench for ex_mem_flag_stage: a table of branch-condition vectors
// plus hand-written sequences for reset, masking, flush, stall and redirect.
module tb_ex_mem_flag_stage;
    import ex_mem_flag_stage_pkg::*;

    typedef struct {
        logic [2:0] flags;   // {V,Z,N} committed before the branch
        logic [2:0] cond;
        logic       taken;
    } br_vec_t;

    localparam int NVEC = 22;

    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    br_vec_t vecs [NVEC];

    ex_mem_flag_stage_if bus ();

    ex_mem_flag_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall        = 1'b0;
        bus.flush        = 1'b0;
        bus.ex_valid     = 1'b0;
        bus.alu_dst      = '0;
        bus.alu_v        = 1'b0;
        bus.alu_z        = 1'b0;
        bus.alu_n        = 1'b0;
        bus.flag_we      = 3'b000;
        bus.ex_is_branch = 1'b0;
        bus.ex_br_cond   = 3'b000;
        bus.ex_br_target = '0;
        bus.ex_rf_we     = 1'b0;
        bus.ex_rf_waddr  = '0;
        bus.ex_mem_rd    = 1'b0;
        bus.ex_mem_wr    = 1'b0;
        bus.ex_st_data   = '0;
    endtask

    // Commit a full {V,Z,N} value through a live non-branch instruction
    task automatic set_flags(input logic [2:0] f);
        idle();
        bus.ex_valid = 1'b1;
        {bus.alu_v, bus.alu_z, bus.alu_n} = f;
        bus.flag_we = 3'b111;
        tick();
        check("set_flags", 32'(bus.flags_q), 32'(f));
    endtask

    initial begin
        vecs[0]  = '{3'b010, BR_EQ, 1'b1};
        vecs[1]  = '{3'b010, BR_NE, 1'b0};
        vecs[2]  = '{3'b100, BR_OV, 1'b1};
        vecs[3]  = '{3'b100, BR_GT, 1'b1};
        vecs[4]  = '{3'b001, BR_LT, 1'b1};
        vecs[5]  = '{3'b001, BR_LE, 1'b1};
        vecs[6]  = '{3'b001, BR_GE, 1'b0};
        vecs[7]  = '{3'b010, BR_GE, 1'b1};
        vecs[8]  = '{3'b000, BR_GE, 1'b1};
        vecs[9]  = '{3'b110, BR_GT, 1'b0};
        vecs[10] = '{3'b000, BR_OV, 1'b0};
        vecs[11] = '{3'b000, BR_LT, 1'b0};
        vecs[12] = '{3'b000, BR_LE, 1'b0};
        vecs[13] = '{3'b010, BR_LE, 1'b1};
        vecs[14] = '{3'b000, BR_UN, 1'b1};
        vecs[15] = '{3'b001, BR_UN, 1'b1};
        vecs[16] = '{3'b010, BR_UN, 1'b1};
        vecs[17] = '{3'b011, BR_UN, 1'b1};
        vecs[18] = '{3'b100, BR_UN, 1'b1};
        vecs[19] = '{3'b101, BR_UN, 1'b1};
        vecs[20] = '{3'b110, BR_UN, 1'b1};
        vecs[21] = '{3'b111, BR_UN, 1'b1};

        // Reset state
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", 32'(bus.flags_q), 32'd0);
        check("reset_ctrl", 32'({bus.mem_valid, bus.mem_rf_we, bus.mem_mem_rd, bus.mem_mem_wr, bus.br_taken}), 32'd0);
        check("reset_data", {bus.mem_result, bus.br_target}, 32'd0);
        rst_n = 1'b1;

        // Flag masking: full update then Z-only update
        bus.ex_valid = 1'b1;
        bus.alu_dst  = 16'h0011;
        {bus.alu_v, bus.alu_z, bus.alu_n} = 3'b101;
        bus.flag_we = 3'b111;
        tick();
        check("mask_all_flags", 32'(bus.flags_q), 32'b101);
        check("mask_valid", 32'(bus.mem_valid), 32'd1);
        check("mask_result", 32'(bus.mem_result), 32'h0011);
        {bus.alu_v, bus.alu_z, bus.alu_n} = 3'b010;
        bus.flag_we = 3'b010;
        tick();
        check("mask_z_only", 32'(bus.flags_q), 32'b111);

        // Flush beats stall; branch in EX is killed
        idle();
        bus.ex_valid = 1'b1;
        bus.ex_rf_we = 1'b1;
        bus.flag_we = 3'b111;
        bus.ex_is_branch = 1'b1;
        bus.ex_br_cond = BR_UN;
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        tick();
        check("flush_stall_valid", 32'(bus.mem_valid), 32'd0);
        check("flush_stall_rf_we", 32'(bus.mem_rf_we), 32'd0);
        check("flush_stall_flags", 32'(bus.flags_q), 32'b111);
        check("flush_stall_br", 32'(bus.br_taken), 32'd0);
        bus.stall = 1'b0;
        tick();
        check("flush_br", 32'(bus.br_taken), 32'd0);
        check("flush_flags", 32'(bus.flags_q), 32'b111);

        // Bubble when EX holds nothing
        idle();
        bus.ex_rf_we = 1'b1;
        bus.ex_mem_rd = 1'b1;
        bus.flag_we = 3'b111;
        tick();
        check("bubble_ctrl", 32'({bus.mem_valid, bus.mem_rf_we, bus.mem_mem_rd}), 32'd0);
        check("bubble_flags", 32'(bus.flags_q), 32'b111);

        // Store transfer into MEM
        idle();
        bus.ex_valid = 1'b1;
        bus.alu_dst = 16'h1234;
        bus.ex_rf_we = 1'b1;
        bus.ex_rf_waddr = 4'hA;
        bus.ex_mem_wr = 1'b1;
        bus.ex_st_data = 16'hBEEF;
        tick();
        check("xfer_result", 32'(bus.mem_result), 32'h1234);
        check("xfer_st_data", 32'(bus.mem_st_data), 32'hBEEF);
        check("xfer_waddr", 32'(bus.mem_rf_waddr), 32'hA);
        check("xfer_ctrl", 32'({bus.mem_valid, bus.mem_rf_we, bus.mem_mem_rd, bus.mem_mem_wr}), 32'b1101);

        // Stall hold for 3 cycles while EX inputs change
        bus.stall = 1'b1;
        bus.flag_we = 3'b111;
        for (int i = 0; i < 3; i++) begin
            bus.alu_dst = 16'h5000 + 16'(i);
            {bus.alu_v, bus.alu_z, bus.alu_n} = 3'(i);
            tick();
            check("stall_result", 32'(bus.mem_result), 32'h1234);
            check("stall_flags", 32'(bus.flags_q), 32'b111);
            check("stall_valid", 32'(bus.mem_valid), 32'd1);
        end

        // Branch that also writes flags evaluates on the old flags
        set_flags(3'b010);
        idle();
        bus.ex_valid = 1'b1;
        bus.ex_is_branch = 1'b1;
        bus.ex_br_cond = BR_EQ;
        bus.ex_br_target = 16'h0040;
        bus.flag_we = 3'b111;
        tick();
        check("own_we_taken", 32'(bus.br_taken), 32'd1);
        check("own_we_target", 32'(bus.br_target), 32'h0040);
        check("own_we_flags", 32'(bus.flags_q), 32'b000);
        // A stall holds the pending redirect
        idle();
        bus.stall = 1'b1;
        tick();
        check("stall_br_hold", 32'(bus.br_taken), 32'd1);
        bus.stall = 1'b0;
        tick();
        check("br_release", 32'(bus.br_taken), 32'd0);

        // Branch condition table
        for (int i = 0; i < NVEC; i++) begin
            set_flags(vecs[i].flags);
            idle();
            bus.ex_valid = 1'b1;
            bus.ex_is_branch = 1'b1;
            bus.ex_br_cond = vecs[i].cond;
            bus.ex_br_target = 16'h0040 + 16'(i);
            {bus.alu_v, bus.alu_z, bus.alu_n} = ~vecs[i].flags;
            tick();
            check($sformatf("br_taken[%0d]", i), 32'(bus.br_taken), 32'(vecs[i].taken));
            if (vecs[i].taken)
                check($sformatf("br_target[%0d]", i), 32'(bus.br_target), 32'h0040 + 32'(i));
            check($sformatf("br_flags[%0d]", i), 32'(bus.flags_q), 32'(vecs[i].flags));
            idle();
            tick();
            check($sformatf("br_pulse[%0d]", i), 32'(bus.br_taken), 32'd0);
        end

        // Mid-operation reset clears a pending redirect without a clock edge
        set_flags(3'b111);
        idle();
        bus.ex_valid = 1'b1;
        bus.ex_is_branch = 1'b1;
        bus.ex_br_cond = BR_UN;
        bus.ex_br_target = 16'h0BAD;
        tick();
        check("pre_reset_br", 32'(bus.br_taken), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_br", 32'(bus.br_taken), 32'd0);
        check("async_reset_flags", 32'(bus.flags_q), 32'd0);
        check("async_reset_valid", 32'(bus.mem_valid), 32'd0);
        check("async_reset_target", 32'(bus.br_target), 32'd0);
        #2;
        rst_n = 1'b1;
        idle();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
